object_sprite: RTL and testbench

Parametrised, moving bitmap sprite for the VGA pixel pipeline, generalising the fixed-position diamond object. It holds a sprite position that bounces inside the active area, updating once per frame during vertical blanking. It drives the row address of an external combinational bitmap ROM and produces a registered per-pixel `sprite_on` for the colour mux. `sprite_on` lags `HCount`/`VCount` by one clock.

---
 rtl/object_sprite.sv | 163 ++++++++++++++++
 tb/tb_object_sprite.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/object_sprite.sv
// object_sprite
//   Moving bitmap sprite for the VGA pixel pipeline. The sprite position
//   bounces inside the active area and updates once per frame, at the start
//   of vertical blanking. The block drives the row address of an external
//   combinational bitmap ROM. It produces a registered per-pixel hit flag
//   for the colour mux. That flag lags HCount/VCount by one clock.
//
// Optional build macro: SPRITE_MIRROR_EN adds input mirror_x, which flips
//   the bitmap horizontally while it is high.
//
// Ports
//   clk        pixel clock; HCount advances once per cycle
//   rst_n      asynchronous active-low reset
//   HCount     current column from the sync generator
//   VCount     current row from the sync generator
//   move_en    enables motion; sampled only at the frame tick
//   speed      pixels per frame on each axis; 0 = stationary
//   rom_addr   combinational ROM row address: VCount - pos_y, truncated
//   rom_data   combinational ROM row; bit i = column i
//   mirror_x   (SPRITE_MIRROR_EN only) horizontal flip
//   sprite_on  registered pixel-hit flag
//   pos_x      current left edge
//   pos_y      current top edge
//   hit_edge   one-cycle pulse after a frame tick on which any axis bounced
module object_sprite #(
  parameter int SPR_W    = 200,
  parameter int SPR_H    = 150,
  parameter int ADDR_W   = 8,
  parameter int X_INIT   = 430,
  parameter int Y_INIT   = 165,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        HCount,
  input  logic [9:0]        VCount,
  input  logic              move_en,
  input  logic [3:0]        speed,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [SPR_W-1:0]  rom_data,
`ifdef SPRITE_MIRROR_EN
  input  logic              mirror_x,
`endif
  output logic              sprite_on,
  output logic [9:0]        pos_x,
  output logic [9:0]        pos_y,
  output logic              hit_edge
);

  localparam int          COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam logic [10:0] X_MAX = 11'(H_ACTIVE - SPR_W);
  localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - SPR_H);

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;     // 0 = increasing, 1 = decreasing
    logic       bounce;
  } axis_t;

  // One axis of bounce motion. The arithmetic is 11 bits wide, so
  // pos + speed never wraps before it is compared against the limit.
  function automatic axis_t step_axis(input logic [9:0]  pos,
                                      input logic        dir,
                                      input logic [3:0]  spd,
                                      input logic [10:0] lim);
    axis_t       r;
    logic [10:0] p;
    logic [10:0] s;
    p        = {1'b0, pos};
    s        = {7'd0, spd};
    r.pos    = pos;
    r.dir    = dir;
    r.bounce = 1'b0;
    if (!dir) begin
      if (p + s >= lim) begin
        r.pos    = lim[9:0];
        r.dir    = 1'b1;
        r.bounce = 1'b1;
      end else begin
        r.pos = 10'(p + s);
      end
    end else begin
      if (p <= s) begin
        r.pos    = 10'd0;
        r.dir    = 1'b0;
        r.bounce = 1'b1;
      end else begin
        r.pos = 10'(p - s);
      end
    end
    return r;
  endfunction

  logic             dir_x, dir_y;
  logic             vblank_q;   // registered VCount == V_ACTIVE compare
  logic             vblank_now;
  logic             tick;
  logic             in_box;
  logic             pix;
  logic [10:0]      col_full;
  logic [COL_W-1:0] col_idx;
  axis_t            nx, ny;

  assign rom_addr = ADDR_W'(VCount - pos_y);

  // Rising edge of the blanking compare, so the tick fires on the first
  // clock of VCount == V_ACTIVE and only once per frame.
  assign vblank_now = (VCount == 10'(V_ACTIVE));
  assign tick       = vblank_now & ~vblank_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    in_box   = 1'b0;
    col_full = {1'b0, HCount} - {1'b0, pos_x};
    col_idx  = col_full[COL_W-1:0];
    pix      = 1'b0;
    if (({1'b0, HCount} >= {1'b0, pos_x}) &&
        ({1'b0, HCount} <= {1'b0, pos_x} + 11'(SPR_W - 1)) &&
        ({1'b0, VCount} >= {1'b0, pos_y}) &&
        ({1'b0, VCount} <= {1'b0, pos_y} + 11'(SPR_H - 1)))
      in_box = 1'b1;
`ifdef SPRITE_MIRROR_EN
    if (mirror_x)
      col_idx = COL_W'(SPR_W - 1) - col_idx;
`endif
    // The range guard only matters outside the box, where the column index
    // can point past the ROM word. That pixel is masked by in_box anyway.
    if (int'(col_idx) < SPR_W)
      pix = rom_data[col_idx];
  end

  always_comb begin
    nx = step_axis(pos_x, dir_x, speed, X_MAX);
    ny = step_axis(pos_y, dir_y, speed, Y_MAX);
  end

  // NOTE: sequential state uses non-blocking assignments. All registers
  // then see the pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x     <= 10'(X_INIT);
      pos_y     <= 10'(Y_INIT);
      dir_x     <= 1'b0;
      dir_y     <= 1'b0;
      vblank_q  <= 1'b0;
      sprite_on <= 1'b0;
      hit_edge  <= 1'b0;
    end else begin
      vblank_q  <= vblank_now;
      sprite_on <= in_box & pix;
      hit_edge  <= tick & move_en & (nx.bounce | ny.bounce);
      if (tick && move_en) begin
        pos_x <= nx.pos;
        dir_x <= nx.dir;
        pos_y <= ny.pos;
        dir_y <= ny.dir;
      end
    end
  end

endmodule

// File: tb/tb_object_sprite.sv
// tb_object_sprite
//   Directed testbench for object_sprite with the default parameters
//   (X_MAX = 440, Y_MAX = 330). A behavioural ROM answers rom_addr:
//   row 0 = bit 0 only, row 1 = bit 199 only, every other row = all ones.
module tb_object_sprite;

  localparam int SPR_W  = 200;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [9:0]        HCount, VCount;
  logic              move_en;
  logic [3:0]        speed;
  logic [ADDR_W-1:0] rom_addr;
  logic [SPR_W-1:0]  rom_data;
  logic              mirror_x;
  logic              sprite_on;
  logic [9:0]        pos_x, pos_y;
  logic              hit_edge;

  int n_checks = 0;
  int n_errors = 0;

  object_sprite dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .HCount   (HCount),
    .VCount   (VCount),
    .move_en  (move_en),
    .speed    (speed),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
`ifdef SPRITE_MIRROR_EN
    .mirror_x (mirror_x),
`endif
    .sprite_on(sprite_on),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .hit_edge (hit_edge)
  );

  always #5 clk = ~clk;

  always_comb begin
    rom_data = '1;
    if (rom_addr == 8'd0) begin
      rom_data    = '0;
      rom_data[0] = 1'b1;
    end else if (rom_addr == 8'd1) begin
      rom_data      = '0;
      rom_data[199] = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step();
  endtask

  // Arrive at the first row of blanking. The edge that ends this task is the
  // tick edge, so the outputs are already the post-tick values.
  task automatic frame_tick(input logic [3:0] spd, input logic men);
    speed   = spd;
    move_en = men;
    VCount  = 10'd479;
    step();
    VCount  = 10'd480;
    step();
  endtask

  // Stay in the blanking row for one more clock and confirm the tick does not
  // fire again: the pulse is gone and the position is stable.
  task automatic settle(input string tag, input logic [9:0] ex, input logic [9:0] ey);
    step();
    check({tag, " hit_edge one-cycle"}, 32'(hit_edge), 32'd0);
    check({tag, " pos_x stable"}, 32'(pos_x), 32'(ex));
    check({tag, " pos_y stable"}, 32'(pos_y), 32'(ey));
    VCount = 10'd481;
    step();
  endtask

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic [7:0] exp_addr;
    logic       exp_on;
  } vec_t;

  initial begin
    vec_t  vecs[12];
    logic  prev_on;
    logic [9:0] ex, ey;

    vecs[0]  = '{10'd430, 10'd165, 8'd0,   1'b1};  // left edge, row 0 bit 0
    vecs[1]  = '{10'd429, 10'd165, 8'd0,   1'b0};  // one left of box
    vecs[2]  = '{10'd431, 10'd165, 8'd0,   1'b0};  // bit 1 clear
    vecs[3]  = '{10'd430, 10'd166, 8'd1,   1'b0};  // row 1 bit 0 clear
    vecs[4]  = '{10'd629, 10'd166, 8'd1,   1'b1};  // last column
    vecs[5]  = '{10'd630, 10'd166, 8'd1,   1'b0};  // one past right edge
    vecs[6]  = '{10'd430, 10'd314, 8'd149, 1'b1};  // last row
    vecs[7]  = '{10'd629, 10'd314, 8'd149, 1'b1};  // bottom-right corner
    vecs[8]  = '{10'd430, 10'd315, 8'd150, 1'b0};  // one below box, ROM ones
    vecs[9]  = '{10'd430, 10'd164, 8'd255, 1'b0};  // one above box, wrapped addr
    vecs[10] = '{10'd429, 10'd200, 8'd35,  1'b0};  // left of box, ROM ones
    vecs[11] = '{10'd500, 10'd200, 8'd35,  1'b1};  // interior

    rst_n    = 1'b0;
    HCount   = '0;
    VCount   = '0;
    move_en  = 1'b0;
    speed    = 4'd0;
    mirror_x = 1'b0;

    // Reset holds with arbitrary raster position.
    for (int i = 0; i < 4; i++) begin
      HCount = 10'($urandom_range(0, 799));
      VCount = 10'($urandom_range(0, 524));
      step();
      check("reset sprite_on", 32'(sprite_on), 32'd0);
      check("reset hit_edge", 32'(hit_edge), 32'd0);
      check("reset pos_x", 32'(pos_x), 32'd430);
      check("reset pos_y", 32'(pos_y), 32'd165);
    end
    HCount = '0;
    VCount = '0;
    @(negedge clk) rst_n = 1'b1;
    step();
    step();

    // Static render. Before each edge the registered flag still shows the
    // previous pixel; after the edge it shows this one.
    prev_on = 1'b0;
    for (int i = 0; i < 12; i++) begin
      HCount = vecs[i].h;
      VCount = vecs[i].v;
      #1;
      check($sformatf("vec%0d rom_addr", i), 32'(rom_addr), 32'(vecs[i].exp_addr));
      check($sformatf("vec%0d latency", i), 32'(sprite_on), 32'(prev_on));
      step();
      check($sformatf("vec%0d sprite_on", i), 32'(sprite_on), 32'(vecs[i].exp_on));
      prev_on = vecs[i].exp_on;
    end

`ifdef SPRITE_MIRROR_EN
    mirror_x = 1'b1;
    HCount = 10'd629; VCount = 10'd165;
    step();
    check("mirror right column", 32'(sprite_on), 32'd1);
    HCount = 10'd430;
    step();
    check("mirror left column", 32'(sprite_on), 32'd0);
    mirror_x = 1'b0;
`endif

    // Right bounce at speed 4: 434, 438, then clamp to 440, then back to 436.
    HCount = '0;
    for (int k = 1; k <= 4; k++) begin
      frame_tick(4'd4, 1'b1);
      ex = (k == 1) ? 10'd434 : (k == 2) ? 10'd438 : (k == 3) ? 10'd440 : 10'd436;
      ey = 10'(165 + 4 * k);
      check($sformatf("right tick%0d pos_x", k), 32'(pos_x), 32'(ex));
      check($sformatf("right tick%0d pos_y", k), 32'(pos_y), 32'(ey));
      check($sformatf("right tick%0d hit_edge", k), 32'(hit_edge), (k == 3) ? 32'd1 : 32'd0);
      settle($sformatf("right tick%0d", k), ex, ey);
    end

    // Tick with motion disabled: everything holds.
    frame_tick(4'd4, 1'b0);
    check("hold pos_x", 32'(pos_x), 32'd436);
    check("hold pos_y", 32'(pos_y), 32'd181);
    check("hold hit_edge", 32'(hit_edge), 32'd0);
    settle("hold", 10'd436, 10'd181);

    // Mid-frame changes of move_en/speed without a tick have no effect.
    VCount = 10'd100;
    for (int i = 0; i < 3; i++) begin
      move_en = ~move_en;
      speed   = 4'(15 - i);
      step();
    end
    check("midframe pos_x", 32'(pos_x), 32'd436);
    check("midframe pos_y", 32'(pos_y), 32'd181);

    // Mid-frame reset after two moves returns to the reset position at once.
    pulse_reset();
    frame_tick(4'd4, 1'b1);
    settle("pre-reset 1", 10'd434, 10'd169);
    frame_tick(4'd4, 1'b1);
    settle("pre-reset 2", 10'd438, 10'd173);
    VCount = 10'd200;
    #2 rst_n = 1'b0;
    #1;
    check("async reset pos_x", 32'(pos_x), 32'd430);
    check("async reset pos_y", 32'(pos_y), 32'd165);
    @(negedge clk) rst_n = 1'b1;
    step();
    frame_tick(4'd4, 1'b1);
    check("post-reset tick pos_x", 32'(pos_x), 32'd434);
    check("post-reset tick pos_y", 32'(pos_y), 32'd169);
    settle("post-reset", 10'd434, 10'd169);

    // Bottom bounce at speed 15. X bounces on the first tick (430+15 >= 440)
    // and then walks down. Y climbs to 330 on tick 11 and returns to 315.
    pulse_reset();
    for (int k = 1; k <= 12; k++) begin
      frame_tick(4'd15, 1'b1);
      ex = (k == 1) ? 10'd440 : 10'(440 - 15 * (k - 1));
      ey = (k <= 11) ? 10'(165 + 15 * k) : 10'd315;
      check($sformatf("bottom tick%0d pos_x", k), 32'(pos_x), 32'(ex));
      check($sformatf("bottom tick%0d pos_y", k), 32'(pos_y), 32'(ey));
      check($sformatf("bottom tick%0d hit_edge", k), 32'(hit_edge),
            (k == 1 || k == 11) ? 32'd1 : 32'd0);
      settle($sformatf("bottom tick%0d", k), ex, ey);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
